// File: rtl/data_memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_arbiter_pkg
//   Shared definitions for the data-memory arbiter and its grant logic.
//   - clog2():     ceiling log2 with a floor of 1 bit, so that an index
//                  always has at least one bit.
//   - tag_width(): width of a read-return tag {valid, core index}.
//   - DEF_*:       default parameter values for the multi-core build.
// ---------------------------------------------------------------------------
package data_memory_arbiter_pkg;

  localparam int DEF_NUM_CORES   = 4;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_MEM_LATENCY = 1;

  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic int tag_width(input int num_cores);
    return clog2(num_cores) + 1;
  endfunction

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational arbiter: request vector plus rotating pointer in, one-hot
//   grant plus encoded winner out. In round-robin mode the search starts at
//   ptr and wraps modulo NUM_CORES; in fixed-priority mode the pointer is
//   ignored and the lowest requesting index wins.
//
//   Ports:
//     req     in   NUM_CORES  request per requester
//     ptr     in   IDX_W      first index searched (round-robin mode)
//     grant   out  NUM_CORES  one-hot grant, all zero when nothing requests
//     winner  out  IDX_W      encoded winner, 0 when nothing requests
//     any     out  1          at least one request granted
// ---------------------------------------------------------------------------
module rr_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter  int NUM_CORES      = DEF_NUM_CORES,
  parameter  int FIXED_PRIORITY = 0,
  localparam int IDX_W          = clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_CORES-1:0] grant,
  output logic [IDX_W-1:0]     winner,
  output logic                 any
);

  int start_idx;
  int cand_idx;

  always_comb begin
    grant     = '0;
    winner    = '0;
    any       = 1'b0;
    cand_idx  = 0;
    start_idx = (FIXED_PRIORITY != 0) ? 0 : int'(ptr);
    // A pointer outside the core range can only come from a corrupted
    // state; restart the search at 0 rather than skipping requesters.
    if (start_idx >= NUM_CORES) begin
      start_idx = 0;
    end
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_idx = start_idx + k;
      if (cand_idx >= NUM_CORES) begin
        cand_idx = cand_idx - NUM_CORES;
      end
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        winner          = IDX_W'(cand_idx);
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// ---------------------------------------------------------------------------
// data_memory_arbiter
//   Shares one single-port, write-first data memory among NUM_CORES cores.
//   One access is issued per cycle (round robin or fixed priority); read
//   data is steered back to the requesting core by a tag shift register
//   that tracks the memory latency. Also ANDs sticky per-core end flags
//   into all_end_process.
//
//   Ports:
//     clock            in   1                   rising-edge clock
//     reset            in   1                   synchronous, active-high
//     core_req         in   NUM_CORES           access request per core
//     core_we          in   NUM_CORES           1 = write, 0 = read
//     core_addr        in   NUM_CORES*ADDR_W    core i at [i*ADDR_W +: ADDR_W]
//     core_wdata       in   NUM_CORES*DATA_W    core i at [i*DATA_W +: DATA_W]
//     core_grant       out  NUM_CORES           one-hot access issued now
//     core_rvalid      out  NUM_CORES           one-hot read data valid
//     core_rdata       out  DATA_W              shared read data
//     mem_write_en     out  1                   memory write_en0
//     mem_addr         out  ADDR_W              memory addr0
//     mem_datain       out  DATA_W              memory datain0
//     mem_dataout      in   DATA_W              memory dataout0
//     end_process_in   in   NUM_CORES           per-core end_process
//     all_end_process  out  1                   every core ended since reset
// ---------------------------------------------------------------------------
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int NUM_CORES      = DEF_NUM_CORES,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MEM_LATENCY    = DEF_MEM_LATENCY,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_grant,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_write_en,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_datain,
  input  logic [DATA_W-1:0]           mem_dataout,
  input  logic [NUM_CORES-1:0]        end_process_in,
  output logic                        all_end_process
);

  localparam int CORE_IDX_W = clog2(NUM_CORES);

  logic [CORE_IDX_W-1:0] rr_ptr;
  logic [NUM_CORES-1:0]  req_gated;
  logic [NUM_CORES-1:0]  grant_p0;
  logic [CORE_IDX_W-1:0] idx_p0;
  logic                  vld_p0;
  logic                  rd_p0;

  logic                  vld_p1 [MEM_LATENCY];
  logic [CORE_IDX_W-1:0] idx_p1 [MEM_LATENCY];

  logic [NUM_CORES-1:0]  end_seen;

  // ---- stage p0: arbitration and memory drive (combinational) ----
  // Requests are masked during reset so nothing is issued to memory.
  assign req_gated = reset ? '0 : core_req;

  rr_arbiter #(
    .NUM_CORES      (NUM_CORES),
    .FIXED_PRIORITY (FIXED_PRIORITY)
  ) u_rr_arbiter (
    .req    (req_gated),
    .ptr    (rr_ptr),
    .grant  (grant_p0),
    .winner (idx_p0),
    .any    (vld_p0)
  );

  assign core_grant   = grant_p0;
  // The arbiter reports winner 0 when idle, so the idle address/data are
  // simply core 0's.
  assign mem_addr     = core_addr[int'(idx_p0)*ADDR_W +: ADDR_W];
  assign mem_datain   = core_wdata[int'(idx_p0)*DATA_W +: DATA_W];
  assign mem_write_en = vld_p0 & core_we[idx_p0];
  assign rd_p0        = vld_p0 & ~core_we[idx_p0];

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (vld_p0) begin
      rr_ptr <= (idx_p0 == CORE_IDX_W'(NUM_CORES - 1)) ? '0 : idx_p0 + 1'b1;
    end
  end

  // ---- stage p1: read tags shifted alongside the memory latency ----
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        vld_p1[i] <= 1'b0;
      end
    end else begin
      vld_p1[0] <= rd_p0;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vld_p1[i] <= vld_p1[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    idx_p1[0] <= idx_p0;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      idx_p1[i] <= idx_p1[i-1];
    end
  end

  // ---- stage p2: registered read return ----
  always_ff @(posedge clock) begin
    if (reset) begin
      core_rvalid <= '0;
      core_rdata  <= '0;
    end else begin
      core_rvalid <= vld_p1[MEM_LATENCY-1]
                   ? (NUM_CORES'(1) << idx_p1[MEM_LATENCY-1]) : '0;
      if (vld_p1[MEM_LATENCY-1]) begin
        core_rdata <= mem_dataout;
      end
    end
  end

  // End flags are sticky; the AND includes this cycle's pulses so the
  // flag rises on the edge right after the last core ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      end_seen        <= '0;
      all_end_process <= 1'b0;
    end else begin
      end_seen        <= end_seen | end_process_in;
      all_end_process <= &(end_seen | end_process_in);
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  core_req;
  logic [3:0]  core_we;
  logic [31:0] core_addr;
  logic [63:0] core_wdata;
  logic [3:0]  core_grant;
  logic [3:0]  core_rvalid;
  logic [15:0] core_rdata;
  logic        mem_write_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_datain;
  logic [15:0] mem_dataout;
  logic [3:0]  end_process_in;
  logic        all_end_process;

  logic [3:0]  fp_req;
  logic [3:0]  fp_grant;
  logic [3:0]  fp_rvalid;
  logic [15:0] fp_rdata;
  logic        fp_mem_write_en;
  logic [7:0]  fp_mem_addr;
  logic [15:0] fp_mem_datain;
  logic        fp_all_end;

  logic [15:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  data_memory_arbiter #(
    .NUM_CORES(4), .ADDR_W(8), .DATA_W(16), .MEM_LATENCY(1), .FIXED_PRIORITY(0)
  ) u_rr (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_grant(core_grant), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout),
    .end_process_in(end_process_in), .all_end_process(all_end_process)
  );

  data_memory_arbiter #(
    .NUM_CORES(4), .ADDR_W(8), .DATA_W(16), .MEM_LATENCY(1), .FIXED_PRIORITY(1)
  ) u_fp (
    .clock(clock), .reset(reset),
    .core_req(fp_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_grant(fp_grant), .core_rvalid(fp_rvalid), .core_rdata(fp_rdata),
    .mem_write_en(fp_mem_write_en), .mem_addr(fp_mem_addr), .mem_datain(fp_mem_datain),
    .mem_dataout(mem_dataout),
    .end_process_in(end_process_in), .all_end_process(fp_all_end)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write-first single-port memory with one cycle of read latency.
  always_ff @(posedge clock) begin
    if (mem_write_en) begin
      mem[mem_addr] <= mem_datain;
    end
    mem_dataout <= mem_write_en ? mem_datain : mem[mem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge, then settle.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic [3:0] we,
                     input logic [31:0] addr, input logic [63:0] wdata);
    @(negedge clock);
    reset          = rst;
    core_req       = req;
    core_we        = we;
    core_addr      = addr;
    core_wdata     = wdata;
    end_process_in = 4'b0000;
    fp_req         = 4'b0000;
    #1;
  endtask

  initial begin
    reset = 1'b1; core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    end_process_in = '0; fp_req = '0;

    // Reset: grants and writes suppressed even with all cores requesting.
    cyc(1'b1, 4'b1111, 4'b1111, 32'h0, 64'h0);
    check_val("rst_grant", 32'(core_grant), 32'h0);
    check_val("rst_wen", 32'(mem_write_en), 32'h0);
    cyc(1'b1, 4'b1111, 4'b1111, 32'h0, 64'h0);
    check_val("rst_rvalid", 32'(core_rvalid), 32'h0);
    check_val("rst_rdata", 32'(core_rdata), 32'h0);
    check_val("rst_all_end", 32'(all_end_process), 32'h0);

    // Core 3 writes 0x1234 to 0x10.
    cyc(1'b0, 4'b1000, 4'b1000, {8'h10, 24'h0}, {16'h1234, 48'h0});
    check_val("wr3_grant", 32'(core_grant), 32'h8);
    check_val("wr3_wen", 32'(mem_write_en), 32'h1);
    check_val("wr3_addr", 32'(mem_addr), 32'h10);
    check_val("wr3_data", 32'(mem_datain), 32'h1234);
    // Core 2 reads 0x10.
    cyc(1'b0, 4'b0100, 4'b0000, {8'h0, 8'h10, 16'h0}, 64'h0);
    check_val("rd2_grant", 32'(core_grant), 32'h4);
    check_val("rd2_wen", 32'(mem_write_en), 32'h0);
    check_val("rd2_addr", 32'(mem_addr), 32'h10);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    check_val("idle_grant", 32'(core_grant), 32'h0);
    check_val("wr3_no_rvalid", 32'(core_rvalid), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    check_val("rd2_rvalid", 32'(core_rvalid), 32'h4);
    check_val("rd2_rdata", 32'(core_rdata), 32'h1234);

    // Core 0 writes 0xBEEF to 0x05, core 1 reads it back next.
    cyc(1'b0, 4'b0001, 4'b0001, 32'h0000_0005, 64'h0000_0000_0000_BEEF);
    check_val("wr0_grant", 32'(core_grant), 32'h1);
    check_val("rd2_rvalid_clear", 32'(core_rvalid), 32'h0);
    cyc(1'b0, 4'b0010, 4'b0000, 32'h0000_0500, 64'h0);
    check_val("rd1_grant", 32'(core_grant), 32'h2);
    check_val("rd1_addr", 32'(mem_addr), 32'h05);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    check_val("wr0_no_rvalid", 32'(core_rvalid), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    check_val("raw_rvalid", 32'(core_rvalid), 32'h2);
    check_val("raw_rdata", 32'(core_rdata), 32'hBEEF);

    // Round robin from reset, all cores reading continuously.
    cyc(1'b1, 4'b0000, 4'b0000, 32'h0, 64'h0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, (k < 8) ? 4'b1111 : 4'b0000, 4'b0000, {8'h10, 8'h05, 8'h10, 8'h05}, 64'h0);
      check_val($sformatf("rr_grant_%0d", k), 32'(core_grant),
                (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
      if (k < 2) begin
        check_val($sformatf("rr_rvalid_%0d", k), 32'(core_rvalid), 32'h0);
      end else begin
        check_val($sformatf("rr_rvalid_%0d", k), 32'(core_rvalid), 32'h1 << ((k - 2) % 4));
        check_val($sformatf("rr_rdata_%0d", k), 32'(core_rdata),
                  (((k - 2) % 2) == 0) ? 32'hBEEF : 32'h1234);
      end
    end

    // Reset while reads from cores 0 and 1 are in flight.
    cyc(1'b0, 4'b0011, 4'b0000, {16'h0, 8'h05, 8'h10}, 64'h0);
    check_val("fl_grant0", 32'(core_grant), 32'h1);
    cyc(1'b0, 4'b0010, 4'b0000, {16'h0, 8'h05, 8'h10}, 64'h0);
    check_val("fl_grant1", 32'(core_grant), 32'h2);
    cyc(1'b1, 4'b1111, 4'b1111, 32'h0, 64'h0);
    check_val("fl_rst_grant", 32'(core_grant), 32'h0);
    check_val("fl_rst_wen", 32'(mem_write_en), 32'h0);
    cyc(1'b0, 4'b1011, 4'b0000, {16'h0, 8'h05, 8'h10}, 64'h0);
    check_val("fl_post_grant", 32'(core_grant), 32'h1);
    check_val("fl_post_rvalid", 32'(core_rvalid), 32'h0);
    check_val("fl_post_rdata", 32'(core_rdata), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    check_val("fl_dropped", 32'(core_rvalid), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    check_val("fl_new_rvalid", 32'(core_rvalid), 32'h1);
    check_val("fl_new_rdata", 32'(core_rdata), 32'h1234);

    // End aggregation: pulses for cores 3, 0, 2, 1.
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    end_process_in = 4'b1000;
    check_val("end_3", 32'(all_end_process), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    end_process_in = 4'b0001;
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    end_process_in = 4'b0100;
    check_val("end_0", 32'(all_end_process), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    end_process_in = 4'b0010;
    check_val("end_2", 32'(all_end_process), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    check_val("end_all_rise", 32'(all_end_process), 32'h1);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    check_val("end_all_hold", 32'(all_end_process), 32'h1);

    // Fixed priority: cores 1 and 3 requesting, core 1 always wins.
    cyc(1'b1, 4'b0000, 4'b0000, 32'h0, 64'h0);
    check_val("end_rst_clear_pending", 32'(fp_grant), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
      fp_req = 4'b1010;
      #1;
      check_val($sformatf("fp_grant_%0d", k), 32'(fp_grant), 32'h2);
    end
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    fp_req = 4'b1000;
    #1;
    check_val("fp_grant_3", 32'(fp_grant), 32'h8);
    check_val("end_after_rst", 32'(all_end_process), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 64'h0);
    check_val("fp_idle", 32'(fp_grant), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
